// File: rtl/fpu_pkg.sv
// fpu_pkg: widths shared across the single-precision FPU datapath.
// MAN_W is the mantissa width with the hidden bit included. The carry-lookahead
// mantissa adder depends on MAN_W = N_GRP * GRP_W, with N_GRP = 2 * SGRP_N.
package fpu_pkg;
  localparam int MAN_W  = 24;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int FMT_W  = 32;

  localparam int GRP_W  = 4;              // bits per level-1 lookahead group
  localparam int N_GRP  = MAN_W / GRP_W;  // level-1 groups (6)
  localparam int SGRP_N = 3;              // level-1 groups per level-2 super-group

  typedef logic [MAN_W-1:0] man_t;
endpackage

// File: rtl/cla4_group.sv
// cla4_group: 4-wide carry-lookahead cell.
// Inputs : i_p[3:0], i_g[3:0] - propagate/generate of the four members
//          i_cin              - carry into member 0
// Outputs: o_gg, o_pg         - group generate / group propagate
//          o_c[3:0]           - carry into each member (o_c[0] = i_cin)
// The same cell serves bits (level 1), groups (level 2) and super-groups
// (level 3). To use fewer than four members, drive the spare slots with p=1 and
// g=0. Those slots then pass the group terms through unchanged.
module cla4_group (
  input  logic [3:0] i_p,
  input  logic [3:0] i_g,
  input  logic       i_cin,
  output logic       o_gg,
  output logic       o_pg,
  output logic [3:0] o_c
);
  // Every carry is a flat sum of products: no member waits on its neighbour.
  assign o_c[0] = i_cin;
  assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_cin);

  assign o_gg = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
              | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
  assign o_pg = &i_p;
endmodule

// File: rtl/mantissa_cla_addsub.sv
// mantissa_cla_addsub: registered 24-bit sign-magnitude mantissa adder/subtractor.
// Inputs : clk, rst (async, active-high), man_x, man_y (aligned mantissas,
//          man_x >= man_y expected when subtracting), sign_x, sign_y,
//          add_sub (0 = x+y, 1 = x-y)
// Outputs: result (magnitude), cout (add overflow / subtract no-borrow),
//          result_sign (= sign_x). All outputs have a latency of one cycle.
// Carries come from a three-level lookahead tree: 6 groups of 4 bits, then 2
// super-groups of 3 groups, then the top level.
module mantissa_cla_addsub
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [MAN_W-1:0] man_x,
  input  logic [MAN_W-1:0] man_y,
  input  logic             sign_x,
  input  logic             sign_y,
  input  logic             add_sub,
  output logic [MAN_W-1:0] result,
  output logic             cout,
  output logic             result_sign
);
  logic             w_operate;
  logic [MAN_W-1:0] w_y_eff;
  logic [MAN_W-1:0] w_p;
  logic [MAN_W-1:0] w_g;
  logic [MAN_W-1:0] w_c_in;
  logic [N_GRP-1:0] w_gin_l2;
  logic [N_GRP-1:0] w_pin_l2;
  logic [N_GRP-1:0] w_cout_l2;
  logic [1:0]       w_gin_l3;
  logic [1:0]       w_pin_l3;
  logic [1:0]       w_cout_l3;
  logic [3:0]       w_l3_c;
  logic [3:0]       w_sg0_c;
  logic [3:0]       w_sg1_c;
  logic             w_gg_top;
  logic             w_pg_top;
  logic             w_cout;
  logic [MAN_W-1:0] w_sum;
  logic [3:0]       w_unused_carries;

  // The operation is a magnitude subtract when the signs differ XOR subtract is requested.
  assign w_operate = sign_x ^ sign_y ^ add_sub;
  assign w_y_eff   = w_operate ? ~man_y : man_y;
  assign w_g       = man_x & w_y_eff;
  assign w_p       = man_x ^ w_y_eff;

  // Level 1: six 4-bit groups. Each one takes its carry-in from level 2.
  genvar gi;
  generate
    for (gi = 0; gi < N_GRP; gi++) begin : g_l1
      cla4_group u_grp (
        .i_p   (w_p[gi*GRP_W +: GRP_W]),
        .i_g   (w_g[gi*GRP_W +: GRP_W]),
        .i_cin (w_cout_l2[gi]),
        .o_gg  (w_gin_l2[gi]),
        .o_pg  (w_pin_l2[gi]),
        .o_c   (w_c_in[gi*GRP_W +: GRP_W])
      );
    end
  endgenerate

  // Level 2: two super-groups of three groups each. The spare fourth slot is transparent.
  cla4_group u_sg0 (
    .i_p   ({1'b1, w_pin_l2[2:0]}),
    .i_g   ({1'b0, w_gin_l2[2:0]}),
    .i_cin (w_cout_l3[0]),
    .o_gg  (w_gin_l3[0]),
    .o_pg  (w_pin_l3[0]),
    .o_c   (w_sg0_c)
  );
  cla4_group u_sg1 (
    .i_p   ({1'b1, w_pin_l2[5:3]}),
    .i_g   ({1'b0, w_gin_l2[5:3]}),
    .i_cin (w_cout_l3[1]),
    .o_gg  (w_gin_l3[1]),
    .o_pg  (w_pin_l3[1]),
    .o_c   (w_sg1_c)
  );
  assign w_cout_l2 = {w_sg1_c[2:0], w_sg0_c[2:0]};

  // Level 3: top-level lookahead across the two super-groups. The carry into bit 0 is the operate signal.
  cla4_group u_top (
    .i_p   ({2'b11, w_pin_l3}),
    .i_g   ({2'b00, w_gin_l3}),
    .i_cin (w_operate),
    .o_gg  (w_gg_top),
    .o_pg  (w_pg_top),
    .o_c   (w_l3_c)
  );
  assign w_cout_l3 = w_l3_c[1:0];
  assign w_cout    = w_gg_top | (w_pg_top & w_operate);
  assign w_sum     = w_p ^ w_c_in;

  // These carries are already provided by the next level up, so they are not used here.
  assign w_unused_carries = {w_sg0_c[3], w_sg1_c[3], w_l3_c[3:2]};

  logic [MAN_W-1:0] r_result;
  logic             r_cout;
  logic             r_result_sign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result      <= '0;
      r_cout        <= 1'b0;
      r_result_sign <= 1'b0;
    end else begin
      r_result      <= w_sum;
      r_cout        <= w_cout;
      r_result_sign <= sign_x;
    end
  end

  assign result      = r_result;
  assign cout        = r_cout;
  assign result_sign = r_result_sign;
endmodule

// File: tb/tb_mantissa_cla_addsub.sv
// tb_mantissa_cla_addsub: directed vectors with hand-computed results, an
// asynchronous-reset check and a 10k random sweep against an arithmetic model.
module tb_mantissa_cla_addsub;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] man_x, man_y;
  logic        sign_x, sign_y, add_sub;
  logic [23:0] result;
  logic        cout, result_sign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mantissa_cla_addsub dut (
    .clk         (clk),
    .rst         (rst),
    .man_x       (man_x),
    .man_y       (man_y),
    .sign_x      (sign_x),
    .sign_y      (sign_y),
    .add_sub     (add_sub),
    .result      (result),
    .cout        (cout),
    .result_sign (result_sign)
  );

  // Comparison packing: {result_sign, cout, result}
  task automatic check(input string tag, input logic [25:0] exp);
    logic [25:0] got;
    got = {result_sign, cout, result};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [23:0] x, input logic [23:0] y,
                       input logic sx, input logic sy, input logic op);
    man_x = x; man_y = y; sign_x = sx; sign_y = sy; add_sub = op;
  endtask

  task automatic step(input string tag, input logic [23:0] x, input logic [23:0] y,
                      input logic sx, input logic sy, input logic op,
                      input logic [23:0] er, input logic ec, input logic es);
    @(negedge clk);
    drive(x, y, sx, sy, op);
    @(posedge clk);
    #1;
    $display("step %s x=%h y=%h sx=%0d sy=%0d as=%0d -> res=%h cout=%0d sign=%0d",
             tag, x, y, sx, sy, op, result, cout, result_sign);
    check(tag, {es, ec, er});
  endtask

  initial begin
    rst = 1'b1;
    drive(24'h0, 24'h0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset_state", 26'h0);
    @(negedge clk);
    rst = 1'b0;

    step("add_basic",   24'hB30967, 24'h4AD278, 0, 0, 0, 24'hFDDBDF, 0, 0);
    step("sub_basic",   24'hB30967, 24'h4AD278, 0, 0, 1, 24'h6836EF, 1, 0);
    step("sx_neg_sub",  24'hB30967, 24'h4AD278, 1, 0, 1, 24'hFDDBDF, 0, 1);
    step("both_neg_sub",24'hB30967, 24'h4AD278, 1, 1, 1, 24'h6836EF, 1, 1);
    step("neg_add_ovf", 24'hB30967, 24'h8FA6E1, 1, 1, 0, 24'h42B048, 1, 1);
    step("neg_sub",     24'hB30967, 24'h8FA6E1, 1, 1, 1, 24'h236286, 1, 1);
    step("sub_hi",      24'h800000, 24'h580000, 0, 0, 1, 24'h280000, 1, 0);
    step("sub_borrow",  24'h940000, 24'h000410, 0, 0, 1, 24'h93FBF0, 1, 0);
    step("add_max",     24'hFFFFFF, 24'hFFFFFF, 0, 0, 0, 24'hFFFFFE, 1, 0);
    step("sub_equal",   24'hABCDEF, 24'hABCDEF, 1, 1, 1, 24'h000000, 1, 1);
    step("sub_negwrap", 24'h000000, 24'h000001, 0, 0, 1, 24'hFFFFFF, 0, 0);
    step("add_mixsign", 24'h123456, 24'h111111, 0, 1, 1, 24'h234567, 0, 0);

    // Asynchronous reset between clock edges. At this point the outputs are non-zero.
    #2;
    rst = 1'b1;
    #1;
    $display("step async_reset -> res=%h cout=%0d sign=%0d", result, cout, result_sign);
    check("async_reset", 26'h0);
    @(posedge clk);
    #1;
    check("reset_held", 26'h0);
    @(negedge clk);
    drive(24'hB30967, 24'h4AD278, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("step post_reset -> res=%h cout=%0d sign=%0d", result, cout, result_sign);
    check("post_reset", {1'b1, 1'b0, 24'hFDDBDF});

    for (int i = 0; i < 10000; i++) begin
      logic [23:0] x, y, t, er;
      logic        sx, sy, op, ec;
      x  = 24'($urandom);
      y  = 24'($urandom);
      sx = 1'($urandom);
      sy = 1'($urandom);
      op = 1'($urandom);
      if ((i % 4) != 0 && x < y) begin
        t = x; x = y; y = t;
      end
      if ((sx ^ sy ^ op) == 1'b0) begin
        {ec, er} = {1'b0, x} + {1'b0, y};
      end else begin
        er = x - y;
        ec = (x >= y);
      end
      @(negedge clk);
      drive(x, y, sx, sy, op);
      @(posedge clk);
      #1;
      if (i < 8)
        $display("step rand%0d x=%h y=%h -> res=%h cout=%0d", i, x, y, result, cout);
      check("random", {sx, ec, er});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
